// File: rtl/cache_ctrl_pkg.sv
// rtl/cache_ctrl_pkg.sv - shared state encoding, geometry and helpers for the 16-word cache controller
package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMP    = 3'd1,
    REFILL = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int LINE_WORDS = 4;
  localparam int NUM_LINES  = 2;

  function automatic logic [LINE_WORDS-1:0] onehot4(input logic [1:0] sel);
    onehot4 = 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/refill_counter.sv
// rtl/refill_counter.sv - loadable down-counter timing a cache line refill
module refill_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/cache_16_controller.sv
// rtl/cache_16_controller.sv - write-through cache sequencer; CACHE_STATS_EN adds hit/miss counters
module cache_16_controller
  import cache_ctrl_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int REFILL_LAT = 2,
  parameter int STAT_W     = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_read,
  input  logic                            req_write,
  input  logic [1:0]                      tag,
  input  logic                            index,
  input  logic [1:0]                      offset,
  input  logic                            hit,
  output logic                            stall,
  output logic                            is_write_mem,
  output logic [LINE_WORDS-1:0]           is_load_bus,
  output logic [1:0]                      control_tag,
  output logic                            control_index,
  output logic [2:0]                      control_offset,
  output logic [LINE_WORDS*NUM_LINES-1:0] control_data_mux,
  output logic                            control_word_cache
`ifdef CACHE_STATS_EN
  ,
  output logic [STAT_W-1:0]               stat_hits,
  output logic [STAT_W-1:0]               stat_miss
`endif
);

  localparam int CW    = $clog2(REFILL_LAT) + 1;
  localparam int MUX_W = LINE_WORDS * NUM_LINES;

  if (REFILL_LAT < 1 || WIDTH < 1 || STAT_W < 1) begin : g_bad_params
    $error("cache_16_controller: REFILL_LAT, WIDTH and STAT_W must be >= 1");
  end

  state_t          state, state_d;
  logic [1:0]      tag_q, tag_n, off_q, off_n;
  logic            idx_q, idx_n, wr_q;
  logic            take, cnt_load, cnt_dec, cnt_zero, fill_last;
  logic [CW-1:0]   cnt;
  logic            wm_d, ci_d, wc_d;
  logic [LINE_WORDS-1:0] lb_d;
  logic [1:0]      ct_d;
  logic [2:0]      co_d;
  logic [MUX_W-1:0] mux_d;

  refill_counter #(.W(CW)) u_refill_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CW'(REFILL_LAT - 1)),
    .dec      (cnt_dec),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    take     = req_read | req_write;
    case (state)
      IDLE:    if (take) state_d = CMP;
      CMP: begin
        if (wr_q)     state_d = WRITE;
        else if (hit) state_d = DONE;
        else begin
          state_d  = REFILL;
          cnt_load = 1'b1;
        end
      end
      REFILL: begin
        if (cnt_zero) state_d = CMP;
        else          cnt_dec = 1'b1;
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    stall = rst & ((state == IDLE) ? take : (state != DONE));

    // Address is captured as the request is taken and held to the end of the transaction
    tag_n = (state == IDLE && take) ? tag    : tag_q;
    idx_n = (state == IDLE && take) ? index  : idx_q;
    off_n = (state == IDLE && take) ? offset : off_q;

    // Outputs are registered, so decode them from the state being entered
    fill_last = (state_d == REFILL) &&
                ((state == CMP) ? (REFILL_LAT == 1) : (cnt == CW'(1)));
    wm_d  = (state_d == WRITE);
    wc_d  = (state_d == WRITE) && hit;
    lb_d  = fill_last ? {LINE_WORDS{1'b1}} : (wc_d ? onehot4(off_n) : '0);
    ct_d  = (state_d == REFILL) ? tag_n : 2'b00;
    ci_d  = (state_d == REFILL || state_d == WRITE) ? idx_n : 1'b0;
    co_d  = (state_d != IDLE) ? {idx_n, off_n} : 3'b000;
    // The datapath numbers the data-mux words from the MSB down
    mux_d = wc_d ? (MUX_W'(8'h80) >> {idx_n, off_n}) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      tag_q <= 2'b00;
      idx_q <= 1'b0;
      off_q <= 2'b00;
      wr_q  <= 1'b0;
    end else begin
      state <= state_d;
      tag_q <= tag_n;
      idx_q <= idx_n;
      off_q <= off_n;
      if (state == IDLE && take) wr_q <= req_write;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_write_mem       <= 1'b0;
      is_load_bus        <= '0;
      control_tag        <= 2'b00;
      control_index      <= 1'b0;
      control_offset     <= 3'b000;
      control_data_mux   <= '0;
      control_word_cache <= 1'b0;
    end else begin
      is_write_mem       <= wm_d;
      is_load_bus        <= lb_d;
      control_tag        <= ct_d;
      control_index      <= ci_d;
      control_offset     <= co_d;
      control_data_mux   <= mux_d;
      control_word_cache <= wc_d;
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_hits <= '0;
      stat_miss <= '0;
    end else begin
      if (state == CMP && hit && (state_d == DONE || state_d == WRITE) && stat_hits != '1)
        stat_hits <= stat_hits + 1'b1;
      if (state == CMP && !wr_q && !hit && stat_miss != '1)
        stat_miss <= stat_miss + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_16_controller.sv
// tb/tb_cache_16_controller.sv - randomized self-checking bench for cache_16_controller
module tb_cache_16_controller;

  localparam int LAT    = 2;
  localparam int STAT_W = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_read = 1'b0, req_write = 1'b0;
  logic [1:0]  tag = 2'b00, offset = 2'b00;
  logic        index = 1'b0;
  logic        hit;
  logic        stall, is_write_mem, control_index, control_word_cache;
  logic [3:0]  is_load_bus;
  logic [1:0]  control_tag;
  logic [2:0]  control_offset;
  logic [7:0]  control_data_mux;
`ifdef CACHE_STATS_EN
  logic [STAT_W-1:0] stat_hits, stat_miss;
`endif

  cache_16_controller #(.WIDTH(32), .REFILL_LAT(LAT), .STAT_W(STAT_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .req_read           (req_read),
    .req_write          (req_write),
    .tag                (tag),
    .index              (index),
    .offset             (offset),
    .hit                (hit),
    .stall              (stall),
    .is_write_mem       (is_write_mem),
    .is_load_bus        (is_load_bus),
    .control_tag        (control_tag),
    .control_index      (control_index),
    .control_offset     (control_offset),
    .control_data_mux   (control_data_mux),
    .control_word_cache (control_word_cache)
`ifdef CACHE_STATS_EN
    ,
    .stat_hits          (stat_hits),
    .stat_miss          (stat_miss)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_hits = 0;
  int exp_miss = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Datapath stand-in: tag/valid array filled by refill pulses
  logic [1:0] vld;
  logic [3:0] tgs;
  logic       preset = 1'b0;

  always @(posedge clk) begin
    if (preset) begin
      vld <= 2'b11;
      tgs <= 4'b0000;
    end else if (rst && is_load_bus == 4'hF) begin
      vld[control_index]           <= 1'b1;
      tgs[control_index*2 +: 2]    <= control_tag;
    end
  end

  always_comb hit = vld[index] && (tgs[index*2 +: 2] == tag);

  task automatic txn(input bit rd, input bit wr, input logic [4:0] addr);
    logic [1:0] t, o, ftag;
    logic       i, fidx, wc_or;
    logic [3:0] lb_or;
    logic [7:0] mux_or;
    logic [2:0] coff;
    bit         h, miss;
    int         ncyc, fills, fill_at, wmem;
    t = addr[4:3]; i = addr[2]; o = addr[1:0];
    h = vld[i] && (tgs[i*2 +: 2] == t);
    miss = !wr && !h;
    ncyc = 0; fills = 0; fill_at = -1; wmem = 0;
    lb_or = 4'h0; mux_or = 8'h00; wc_or = 1'b0; coff = 3'b000; ftag = 2'b00; fidx = 1'b0;
    @(posedge clk); #1;
    req_read = rd; req_write = wr; tag = t; index = i; offset = o;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (!stall) break;
      if (c == 1) coff = control_offset;
      if (is_load_bus == 4'hF) begin
        fills++; fill_at = c; ftag = control_tag; fidx = control_index;
      end else begin
        lb_or |= is_load_bus;
      end
      mux_or |= control_data_mux;
      wc_or  |= control_word_cache;
      if (is_write_mem) wmem++;
      ncyc++;
    end
    check("stall_cycles", ncyc, wr ? 3 : (h ? 2 : 3 + LAT));
    check("cmp_offset", 32'({coff}), 32'({i, o}));
    check("mem_writes", wmem, wr ? 1 : 0);
    check("refills", fills, miss ? 1 : 0);
    if (miss) begin
      check("refill_cycle", fill_at, 1 + LAT);
      check("refill_tag", 32'(ftag), 32'(t));
      check("refill_index", 32'(fidx), 32'(i));
    end
    check("word_loads", 32'(lb_or), (wr && h) ? (32'd1 << o) : 32'd0);
    check("data_mux", 32'(mux_or), (wr && h) ? (32'h80 >> {i, o}) : 32'd0);
    check("word_cache", 32'(wc_or), (wr && h) ? 32'd1 : 32'd0);
    if (wr) exp_hits += h ? 1 : 0;
    else if (h) exp_hits++;
    else begin exp_miss++; exp_hits++; end
    @(posedge clk); #1;
    req_read = 1'b0; req_write = 1'b0;
    @(negedge clk);
    check("idle_stall", 32'(stall), 32'd0);
  endtask

  initial begin
    preset = 1'b1;
    #1;
    check("reset_outputs", 32'({stall, is_write_mem, is_load_bus, control_tag, control_index,
                               control_offset, control_data_mux, control_word_cache}), 32'd0);
`ifdef CACHE_STATS_EN
    check("reset_stats", 32'({stat_hits, stat_miss}), 32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    preset = 1'b0;
    rst = 1'b1;

    txn(1'b1, 1'b0, 5'd5);
    txn(1'b0, 1'b1, 5'd2);
    txn(1'b0, 1'b1, 5'd18);
    txn(1'b1, 1'b0, 5'd26);
    txn(1'b1, 1'b1, 5'd26);

    // Asynchronous reset while the refill counter still reads 1
    @(posedge clk); #1;
    req_read = 1'b1; tag = tgs[1:0] + 2'd1; index = 1'b0; offset = 2'd1;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrefill_reset", 32'({stall, is_write_mem, is_load_bus, control_tag, control_index,
                                 control_offset, control_data_mux, control_word_cache}), 32'd0);
    exp_hits = 0; exp_miss = 0;
    @(negedge clk);
    check("midrefill_no_fill", 32'(is_load_bus), 32'd0);
    req_read = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_stall", 32'(stall), 32'd0);

    for (int n = 0; n < 40; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      txn(kind != 1, kind != 0, 5'($urandom_range(0, 31)));
    end

`ifdef CACHE_STATS_EN
    check("stat_hits", 32'(stat_hits), exp_hits);
    check("stat_miss", 32'(stat_miss), exp_miss);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
